t07_spi_tft_master: RTL and testbench



---
 rtl/t07_spi_tft_master_pkg.sv | 23 ++
 rtl/t07_spi_tft_master_if.sv | 30 +++
 rtl/t07_spi_tft_master_clkgen.sv | 41 ++++
 rtl/t07_spi_tft_master.sv | 177 +++++++++++++++++
 tb/tb_t07_spi_tft_master.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t07_spi_tft_master_pkg.sv
// t07_spi_pkg: shared types and constants for the RA8875 SPI master.
// FSM state encoding, default widths and RA8875 command-byte prefixes.
package t07_spi_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int DIV_W_DEF   = 8;
  localparam int DELAY_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // RA8875 first-byte opcodes (placed in the frame MSBs)
  localparam logic [7:0] RA_DATA_WR = 8'h00;
  localparam logic [7:0] RA_DATA_RD = 8'h40;
  localparam logic [7:0] RA_CMD_WR  = 8'h80;
  localparam logic [7:0] RA_STAT_RD = 8'hC0;

endpackage

// File: rtl/t07_spi_tft_master_if.sv
// t07_spi_tft_master_if: request/response bus between the memory handler
// (master side) and the SPI master block (slave side).
interface t07_spi_tft_master_if
  import t07_spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF
);

  logic               req_valid;
  logic               req_ready;
  logic [DATA_W-1:0]  req_data;
  logic               req_read;
  logic [DIV_W-1:0]   req_div;
  logic [DELAY_W-1:0] req_delay;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_data;

  modport master (
    output req_valid, req_data, req_read, req_div, req_delay,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_read, req_div, req_delay,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/t07_spi_tft_master_clkgen.sv
// t07_spi_clkgen: half-period timer for the SPI master.
// Emits a one-cycle tick every (i_div+1) cycles while enabled and toggles
// the registered sclk on each tick when toggling is permitted. Disabling
// clears both the counter and sclk, so every enabled run starts from zero.
module t07_spi_clkgen
  import t07_spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sclk_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_sclk
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;

  assign o_tick = i_en && (r_cnt == i_div);
  assign o_sclk = r_sclk;

  // Half-period counter 0..i_div and sclk toggle on terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (r_cnt == i_div) begin
      r_cnt <= '0;
      if (i_sclk_en) r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/t07_spi_tft_master.sv
// t07_spi_tft_master: SPI mode-0 master for the RA8875 TFT controller.
// One frame per handshake, MSB first, programmable sclk half-period and
// post-frame chip-select gap. Define T07_SPI_READ_EN to build the MISO
// capture path and read response; without it every frame is a write.
module t07_spi_tft_master
  import t07_spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  t07_spi_tft_master_if.slave     bus,
  output logic                    cs_n,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int BCNT_W = $clog2(2*DATA_W) + 1;
  localparam logic [BCNT_W-1:0] LAST_HALF = BCNT_W'(2*DATA_W - 1);
  localparam logic [BCNT_W-1:0] LAST_FALL = BCNT_W'(2*DATA_W - 2);

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [DIV_W-1:0]   r_div;
  logic [DELAY_W-1:0] r_delay;
  logic [DELAY_W-1:0] r_gap_cnt;
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic               r_cs_n;
  logic               r_mosi;
  logic               r_ready;

  logic w_tick;
  logic w_sclk;
  logic w_clk_en;
  logic w_sclk_en;
  logic w_accept;
  logic w_fall_shift;

  // Divider runs through SETUP/SHIFT/HOLD; the last SHIFT half leaves sclk low
  assign w_clk_en  = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
  assign w_sclk_en = (r_state == ST_SETUP) || ((r_state == ST_SHIFT) && (r_bit_cnt != LAST_HALF));
  assign w_accept  = (r_state == ST_IDLE) && r_ready && bus.req_valid;
  // Falling edges present the next bit, except the one after the final rise
  assign w_fall_shift = w_tick && (r_state == ST_SHIFT) && !r_bit_cnt[0] && (r_bit_cnt != LAST_FALL);

  t07_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_clk_en),
    .i_sclk_en (w_sclk_en),
    .i_div     (r_div),
    .o_tick    (w_tick),
    .o_sclk    (w_sclk)
  );

  assign bus.req_ready = r_ready;
  assign cs_n          = r_cs_n;
  assign sclk          = w_sclk;
  assign mosi          = r_mosi;

  // Frame sequencer: accept, setup, shift, hold, chip-select gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (bus.req_valid) begin
            r_ready   <= 1'b0;
            r_cs_n    <= 1'b0;
            r_mosi    <= bus.req_data[DATA_W-1];
            r_bit_cnt <= '0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_bit_cnt <= '0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            if (w_fall_shift) r_mosi <= r_shift[DATA_W-2];
            if (r_bit_cnt == LAST_HALF) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_gap_cnt <= '0;
            if (r_delay == '0) begin
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == r_delay - DELAY_W'(1)) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + DELAY_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-request frame, divider and gap captured at accept; frame shifts on falls
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= bus.req_data;
      r_div   <= bus.req_div;
      r_delay <= bus.req_delay;
    end else if (w_fall_shift) begin
      r_shift <= {r_shift[DATA_W-2:0], 1'b0};
    end
  end

`ifdef T07_SPI_READ_EN
  logic              r_read;
  logic [DATA_W-1:0] r_cap;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_rise;

  // MISO is taken on the same edge that drives sclk high
  assign w_rise = w_tick && ((r_state == ST_SETUP) ||
                  ((r_state == ST_SHIFT) && r_bit_cnt[0] && (r_bit_cnt != LAST_HALF)));

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  // Read flag latched at accept; capture register shifts MISO in at the LSB
  always_ff @(posedge clk) begin
    if (w_accept) r_read <= bus.req_read;
    if (w_rise && r_read) r_cap <= {r_cap[DATA_W-2:0], miso};
  end

  // Response published together with the cs_n rise of a read frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if ((r_state == ST_HOLD) && w_tick && r_read) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_cap;
      end
    end
  end
`else
  logic w_unused_rd;

  assign w_unused_rd   = miso ^ bus.req_read;
  assign bus.rsp_valid = 1'b0;
  assign bus.rsp_data  = '0;
`endif

endmodule

// File: tb/tb_t07_spi_tft_master.sv
// Testbench for t07_spi_tft_master: directed frames with a queue-based
// scoreboard. A monitor reassembles each SPI frame and each read response
// and compares them against the expectations queued by the stimulus.
module tb_t07_spi_tft_master;
  import t07_spi_pkg::*;

  localparam int DATA_W  = 16;
  localparam int DIV_W   = 8;
  localparam int DELAY_W = 16;
  localparam int LIMIT   = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n, sclk, mosi;
  logic miso = 1'b0;

  t07_spi_tft_master_if #(.DATA_W(DATA_W), .DIV_W(DIV_W), .DELAY_W(DELAY_W)) bus ();

  t07_spi_tft_master #(.DATA_W(DATA_W), .DIV_W(DIV_W), .DELAY_W(DELAY_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .cs_n (cs_n),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] word;
    int                low;
    int                rises;
  } frame_t;

  frame_t            exp_frames[$];
  logic [DATA_W-1:0] exp_rsp[$];

`ifdef T07_SPI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI slave model: MSB on cs_n fall, next bit on each sclk fall
  logic [DATA_W-1:0] slave_word = '0;
  int                slave_idx  = 0;

  always @(negedge cs_n) begin
    slave_idx = DATA_W - 2;
    miso      = slave_word[DATA_W-1];
  end

  always @(negedge sclk) begin
    if (!cs_n && slave_idx >= 0) begin
      miso = slave_word[slave_idx];
      slave_idx--;
    end
  end

  // Monitor: rebuild frames from the pins and check responses
  int                mon_low   = 0;
  int                mon_rises = 0;
  logic [DATA_W-1:0] mon_word  = '0;
  logic              prev_cs   = 1'b1;
  logic              prev_sclk = 1'b0;
  frame_t            mon_f;
  logic [DATA_W-1:0] mon_r;

  always @(negedge clk) begin
    if (rst) begin
      mon_low   = 0;
      mon_rises = 0;
      mon_word  = '0;
    end else begin
      if (!cs_n) begin
        mon_low++;
        if (sclk && !prev_sclk) begin
          mon_rises++;
          mon_word = {mon_word[DATA_W-2:0], mosi};
        end
      end
      if (cs_n && !prev_cs) begin
        if (exp_frames.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got word 0x%0h, expected no frame", mon_word);
        end else begin
          mon_f = exp_frames.pop_front();
          chk("frame_mosi", 32'(mon_word), 32'(mon_f.word));
          chk("frame_cs_low", mon_low, mon_f.low);
          chk("frame_rises", mon_rises, mon_f.rises);
        end
        mon_low   = 0;
        mon_rises = 0;
        mon_word  = '0;
      end
      if (bus.rsp_valid) begin
        chk("rsp_at_cs_rise", 32'(cs_n && !prev_cs), 32'd1);
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got 0x%0h, expected no response", bus.rsp_data);
        end else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_data", 32'(bus.rsp_data), 32'(mon_r));
        end
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  // Issue one request at a negedge; it is accepted on the following posedge
  task automatic issue(input logic [DATA_W-1:0] data, input logic rd, input logic [DIV_W-1:0] div,
                       input logic [DELAY_W-1:0] dly, input logic [DATA_W-1:0] sword, input bit push);
    int n;
    frame_t f;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=0 after %0d cycles, expected 1", n);
    end
    slave_word    = sword;
    bus.req_valid = 1'b1;
    bus.req_data  = data;
    bus.req_read  = rd;
    bus.req_div   = div;
    bus.req_delay = dly;
    if (push) begin
      f.word  = data;
      f.low   = (2*DATA_W + 2) * (int'(div) + 1);
      f.rises = DATA_W;
      exp_frames.push_back(f);
      if (rd && READ_EN) exp_rsp.push_back(sword);
    end
    @(posedge clk);
    #1;
    // Scramble the inputs: the block must have latched everything at accept
    bus.req_valid = 1'b0;
    bus.req_data  = ~data;
    bus.req_read  = ~rd;
    bus.req_div   = div + DIV_W'(3);
    bus.req_delay = dly + DELAY_W'(5);
  endtask

  // Count negedges (from the accept-cycle negedge) until req_ready is high
  task automatic measure_ready(input string name, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < LIMIT);
    chk(name, n, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 ns, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc;
    logic ps;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_read  = 1'b0;
    bus.req_div   = '0;
    bus.req_delay = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Command write 0x80A5, H=1, no gap: 34 low cycles, ready at T+35
    issue({RA_CMD_WR, 8'hA5}, 1'b0, 8'd0, 16'd0, 16'h0000, 1'b1);
    measure_ready("ready_t1", 35);

    // Write 0x0001, H=4: 136 low cycles
    issue(16'h0001, 1'b0, 8'd3, 16'd0, 16'h0000, 1'b1);
    measure_ready("ready_t2", 137);

    // Read 0x4000 with slave word 0x3C5A, H=2, gap 2
    issue({RA_DATA_RD, 8'h00}, 1'b1, 8'd1, 16'd2, 16'h3C5A, 1'b1);
    measure_ready("ready_t3", 71);
    chk("rsp_hold_t3", 32'(bus.rsp_data), READ_EN ? 32'h3C5A : 32'h0);

    // Read at H=1 with slave word 0xA5C3
    issue({RA_STAT_RD, 8'h00}, 1'b1, 8'd0, 16'd0, 16'hA5C3, 1'b1);
    measure_ready("ready_t3b", 35);

    // Write leaves rsp_data unchanged
    issue({RA_DATA_WR, 8'h34}, 1'b0, 8'd0, 16'd0, 16'hFFFF, 1'b1);
    measure_ready("ready_t4", 35);
    chk("rsp_hold_write", 32'(bus.rsp_data), READ_EN ? 32'hA5C3 : 32'h0);

    // Back-to-back writes with gap 10 and req_valid held high
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = 16'h00FF;
    bus.req_read  = 1'b0;
    bus.req_div   = 8'd0;
    bus.req_delay = 16'd10;
    exp_frames.push_back('{word: 16'h00FF, low: 34, rises: DATA_W});
    exp_frames.push_back('{word: 16'hFF00, low: 34, rises: DATA_W});
    @(posedge clk);
    #1;
    bus.req_data = 16'hFF00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cs_n && n < LIMIT);
    n  = 0;
    rc = 0;
    while (cs_n && n < LIMIT) begin
      n++;
      if (bus.req_ready) rc++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    // Gap cycles plus the single accept cycle in IDLE
    chk("b2b_cs_high", n, 11);
    chk("b2b_ready_cycles", rc, 1);
    measure_ready("ready_b2b", 44);

    // Maximum divider: H=256
    issue(16'hA55A, 1'b0, 8'd255, 16'd0, 16'h0000, 1'b1);
    measure_ready("ready_maxdiv", 1 + 34 * 256);

    // Reset at the 7th sclk rise of a frame that is then discarded
    issue(16'h5A5A, 1'b1, 8'd1, 16'd0, 16'hFFFF, 1'b0);
    n  = 0;
    rc = 0;
    ps = 1'b0;
    while (rc < 7 && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (sclk && !ps) rc++;
      ps = sclk;
    end
    chk("abort_reached_rise7", rc, 7);
    rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
    issue(16'hC3C3, 1'b0, 8'd0, 16'd0, 16'h0000, 1'b1);
    measure_ready("ready_after_abort_frame", 35);

    repeat (4) @(negedge clk);
    chk("frames_drained", exp_frames.size(), 0);
    chk("rsp_drained", exp_rsp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
